// File: rtl/nes_pad_emulator_if.sv
// Pad-side signal bundle for the NES serial joypad emulator.
// The fixture/console side uses master; the emulator uses slave.
interface nes_pad_emulator_if #(
  parameter int NUM_BUTTONS = 8
);
  logic [NUM_BUTTONS-1:0] buttons;
  logic                   nes_latch;
  logic                   nes_pulse;
  logic                   nes_data;
  logic                   busy;
  logic                   frame_done;

  modport master (
    output buttons,
    output nes_latch,
    output nes_pulse,
    input  nes_data,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  buttons,
    input  nes_latch,
    input  nes_pulse,
    output nes_data,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/nes_pad_emulator.sv
// 4021-style NES joypad responder: captures the button vector while latch is
// high and shifts it out LSB first, active-low, one bit per pulse rising edge.
module nes_pad_emulator #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_BUTTONS = 8
) (
  input  logic               clk,
  input  logic               hard_reset,
  nes_pad_emulator_if.slave  pad
);

  localparam int CntW = $clog2(NUM_BUTTONS + 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift
  } state_e;

  logic [SYNC_STAGES-1:0] lat_sync_q;
  logic [SYNC_STAGES-1:0] pul_sync_q;
  logic                   lat_prev_q;
  logic                   pul_prev_q;
  logic                   lat_s;
  logic                   pul_s;
  logic                   lat_rise;
  logic                   lat_fall;
  logic                   pul_rise;

  state_e                 state_q;
  logic [NUM_BUTTONS-1:0] shreg_q;
  logic [CntW-1:0]        bit_cnt_q;

  // Synchronizers and one-flop edge detectors for the asynchronous console pins.
  always_ff @(posedge clk) begin
    if (hard_reset) begin
      lat_sync_q <= '0;
      pul_sync_q <= '0;
      lat_prev_q <= 1'b0;
      pul_prev_q <= 1'b0;
    end else begin
      lat_sync_q <= {lat_sync_q[SYNC_STAGES-2:0], pad.nes_latch};
      pul_sync_q <= {pul_sync_q[SYNC_STAGES-2:0], pad.nes_pulse};
      lat_prev_q <= lat_s;
      pul_prev_q <= pul_s;
    end
  end

  always_comb begin
    lat_s    = lat_sync_q[SYNC_STAGES-1];
    pul_s    = pul_sync_q[SYNC_STAGES-1];
    lat_rise = lat_s & ~lat_prev_q;
    lat_fall = ~lat_s & lat_prev_q;
    pul_rise = pul_s & ~pul_prev_q;
  end

  // nes_data trails shreg[0] by one register so the line is glitch-free.
  always_ff @(posedge clk) begin
    if (hard_reset) begin
      state_q        <= StIdle;
      shreg_q        <= '1;
      bit_cnt_q      <= '0;
      pad.nes_data   <= 1'b1;
      pad.busy       <= 1'b0;
      pad.frame_done <= 1'b0;
    end else begin
      pad.frame_done <= 1'b0;
      pad.nes_data   <= shreg_q[0];
      unique case (state_q)
        StIdle: begin
          if (lat_rise) begin
            state_q   <= StLoad;
            shreg_q   <= ~pad.buttons;
            bit_cnt_q <= '0;
            pad.busy  <= 1'b1;
          end
        end
        StLoad: begin
          bit_cnt_q <= '0;
          if (lat_s) begin
            shreg_q <= ~pad.buttons;
          end
          if (lat_fall) begin
            state_q <= StShift;
          end
        end
        StShift: begin
          // A new latch aborts the frame and takes priority over a coincident pulse.
          if (lat_rise) begin
            state_q   <= StLoad;
            shreg_q   <= ~pad.buttons;
            bit_cnt_q <= '0;
          end else if (pul_rise) begin
            shreg_q <= {1'b0, shreg_q[NUM_BUTTONS-1:1]};
            if (bit_cnt_q == CntW'(NUM_BUTTONS - 1)) begin
              bit_cnt_q      <= CntW'(NUM_BUTTONS);
              pad.frame_done <= 1'b1;
              pad.busy       <= 1'b0;
              state_q        <= StIdle;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q  <= StIdle;
          pad.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
